// File: rtl/osc_pkg.sv
// osc_pkg: shared types and sizing helper for the oscillation monitor
package osc_pkg;
    typedef enum logic [1:0] {SEARCH, LONG, SHORT} state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_LONG_SHORT, ERR_LONG_LONG, ERR_SHORT_BAD} err_t;
    function automatic int cw_of(input int delay);
        return $clog2(2 * (delay + 2) + 1);
    endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer with edge detect
// clk, rst_n (sync, active-low); d async input; sync synchronized level; rise/fall single-cycle edge flags
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/osc_monitor.sv
// osc_monitor: checks heartbeat long/short phase timing, reports lock, errors and stuck line
// clk, rst_n (sync, active-low); osc_in async heartbeat; long_on polarity of the long phase
// locked, err_pulse, err_code (last error), stuck (no edge for TIMEOUT), long_meas (last long phase length)
module osc_monitor
    import osc_pkg::*;
#(
    parameter int DELAY = 20,
    parameter int TOL = 2,
    parameter int LOCK_CNT = 4,
    localparam int CW = cw_of(DELAY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          osc_in,
    input  logic          long_on,
    output logic          locked,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic          stuck,
    output logic [CW-1:0] long_meas
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] TIMEOUT = CW'(2 * (DELAY + 2));
    localparam logic [CW-1:0] LONG_MIN = CW'(DELAY + 1 - TOL);
    localparam logic [CW-1:0] LONG_LIM = CW'(DELAY + 2 + TOL);
    localparam logic [CW-1:0] SHORT_MAX = CW'(1 + TOL);
    localparam logic [CW-1:0] SHORT_LIM = CW'(2 + TOL);
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_CNT);
    state_t state, state_n;
    err_t code, code_n;
    logic [CW-1:0] run, run_n, meas_n;
    logic [GW-1:0] good, good_n;
    logic sync, rise, fall, s, edge_s, s_rise, s_fall;
    logic pol_q, chg, long_ok, long_ok_n, err_n, stuck_n, locked_n;
    sync_edge u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (osc_in),
        .sync (sync),
        .rise (rise),
        .fall (fall)
    );
    // polarity-normalized level; any raw edge is an edge of s, its direction set by the new level
    assign s      = long_on ? sync : ~sync;
    assign edge_s = rise | fall;
    assign s_rise = edge_s & s;
    assign s_fall = edge_s & ~s;
    assign chg    = long_on != pol_q;
    assign err_code = code;
    always_comb begin
        state_n   = state;
        good_n    = good;
        long_ok_n = long_ok;
        meas_n    = long_meas;
        code_n    = code;
        err_n     = 1'b0;
        case (state)
            SEARCH: state_n = s_rise ? LONG : SEARCH;
            LONG: begin
                if (s_fall) begin
                    state_n   = SHORT;
                    long_ok_n = run >= LONG_MIN;
                    err_n     = !long_ok_n;
                    code_n    = err_n ? ERR_LONG_SHORT : code;
                    meas_n    = err_n ? long_meas : run;
                end else if (run >= LONG_LIM) begin
                    state_n = SEARCH;
                    err_n   = 1'b1;
                    code_n  = ERR_LONG_LONG;
                end
            end
            SHORT: begin
                if (s_rise) begin
                    state_n = LONG;
                    err_n   = run > SHORT_MAX;
                    code_n  = err_n ? ERR_SHORT_BAD : code;
                    good_n  = (err_n || !long_ok || good == LOCK_N) ? good : good + 1'b1;
                end else if (run >= SHORT_LIM) begin
                    state_n = SEARCH;
                    err_n   = 1'b1;
                    code_n  = ERR_SHORT_BAD;
                end
            end
            default: state_n = SEARCH;
        endcase
        good_n = err_n ? '0 : good_n;
        // a polarity change restarts acquisition silently, overriding anything evaluated this cycle
        if (chg) begin
            state_n   = SEARCH;
            good_n    = '0;
            long_ok_n = 1'b0;
            meas_n    = long_meas;
            code_n    = code;
            err_n     = 1'b0;
        end
        run_n    = chg ? '0 : edge_s ? CW'(1) : (run == TIMEOUT) ? run : run + 1'b1;
        stuck_n  = !chg && !edge_s && (stuck || run_n == TIMEOUT);
        locked_n = (good_n == LOCK_N) && !stuck_n;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEARCH;
            run       <= '0;
            good      <= '0;
            long_ok   <= 1'b0;
            pol_q     <= long_on;
            code      <= ERR_NONE;
            err_pulse <= 1'b0;
            stuck     <= 1'b0;
            locked    <= 1'b0;
            long_meas <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            good      <= good_n;
            long_ok   <= long_ok_n;
            pol_q     <= long_on;
            code      <= code_n;
            err_pulse <= err_n;
            stuck     <= stuck_n;
            locked    <= locked_n;
            long_meas <= meas_n;
        end
    end
endmodule

// File: doc/osc_monitor.md
# osc_monitor

Receive-side checker for the heartbeat waveform produced by the team's oscillating-signal generator. Samples the incoming oscillation, normalizes polarity, measures every long and short phase against the generator's nominal timing, and reports lock, per-period errors and a stuck-line condition. Sits at a board or DAQ link input, next to status/LED logic, wherever a peer block's heartbeat must be supervised.

## Interface
Parameters:
- DELAY, 20: generator's DELAY setting. Nominal long phase = DELAY+1 cycles, short phase = 1 cycle, period = DELAY+2.
- TOL, 2: accepted deviation in cycles. Long phase in [DELAY+1-TOL, DELAY+1+TOL]; short phase in [1, 1+TOL].
- LOCK_CNT, 4: consecutive good periods required to assert locked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  **synchronous, active-low reset**.
- osc_in  in  1  incoming heartbeat; may be asynchronous to clk.
- long_on  in  1  polarity: 1 means the long phase is high, 0 means the long phase is low.
- locked  out  1  LOCK_CNT consecutive good periods seen since the last error, reset or polarity change.
- err_pulse  out  1  one-cycle strobe on each detected period error.
- err_code  out  2  code of the most recent error; holds until the next error. 0 = NONE, 1 = LONG_SHORT, 2 = LONG_LONG, 3 = SHORT_BAD.
- stuck  out  1  no edge seen for TIMEOUT = 2*(DELAY+2) cycles; level output.
- long_meas  out  CW  length of the last completed long phase. CW = $clog2(2*(DELAY+2)+1).

## Operation
- osc_in passes through a 2-flop synchronizer. Normalized s = long_on ? sync : ~sync. Rising edge of s starts a long phase; falling edge of s starts a short phase.
- A single run counter (CW bits) clears to 1 on every edge of s, increments otherwise, and saturates at TIMEOUT.
- States:
  - SEARCH: wait for a rising edge of s, then go to LONG. No errors are raised in this state.
  - LONG: on a falling edge, if run < DELAY+1-TOL, raise LONG_SHORT; otherwise load long_meas with the run. Either way, go to SHORT. If run reaches DELAY+2+TOL before any edge, raise LONG_LONG once and go to SEARCH.
  - SHORT: on a rising edge, if run > 1+TOL, raise SHORT_BAD; otherwise the period is good (provided the preceding LONG was good) and good_cnt increments. Either way, go to LONG. If run reaches 2+TOL with no edge, raise SHORT_BAD once and go to SEARCH.
- good_cnt saturates at LOCK_CNT. locked = (good_cnt == LOCK_CNT). Any error clears good_cnt and therefore locked.
- stuck sets when run reaches TIMEOUT, in any state. It clears on the next edge of s. While stuck, locked = 0.
- A change of long_on (registered compare) forces SEARCH, clears good_cnt, the run counter and stuck, and raises no error. The synchronizer is not flushed.
- Reset values: locked=0, err_pulse=0, err_code=NONE, stuck=0, long_meas=0, state=SEARCH, good_cnt=0, run=0, synchronizer=0.

## Timing
- Latency from an osc_in transition to an internally visible edge is 2 cycles (synchronizer). All outputs are registered one more cycle, so osc_in transition to output change is 3 cycles.
- err_pulse is high for exactly 1 cycle per error. err_code updates in the same cycle.
- locked rises in the cycle after the LOCK_CNT-th good rising edge is evaluated. It falls in the same cycle err_pulse rises.
- Simultaneous run-limit and edge in the same cycle: the edge wins and is evaluated normally.
- Simultaneous long_on change and error: the polarity change wins and no err_pulse is raised.
- rst_n low at any point overrides everything and restores reset values on the next clk.

## Structure
- Shared package osc_pkg holds:
  - the state enum {SEARCH, LONG, SHORT};
  - the err_code enum {ERR_NONE, ERR_LONG_SHORT, ERR_LONG_LONG, ERR_SHORT_BAD};
  - a function computing CW from DELAY.
- One sub-module, sync_edge: 2-flop synchronizer plus previous-value register, with outputs sync, rise and fall.
- Target size: approximately 150-250 lines of RTL.

## Test plan
All scenarios use DELAY=20, TOL=2, LOCK_CNT=4.
- Clean stream (21 high / 1 low, long_on=1) -> locked=1 after the 4th good period; long_meas=21; err_pulse never fires.
- One long phase of 17 while locked -> err_code=1, single err_pulse, locked=0. After 4 more good periods, locked=1.
- Long phase held for 30 -> LONG_LONG raised when run reaches 24, state returns to SEARCH. The next rising edge restarts measurement with no extra error.
- osc_in held constant after lock -> stuck=1 exactly 44 cycles after the last edge, locked=0. stuck clears 3 cycles after the next osc_in transition.
- long_on=0 with an inverted stream (21 low / 1 high) -> locks exactly as in the first scenario. Toggling long_on mid-stream clears lock with no err_pulse.
- rst_n=0 asserted mid-lock for 1 cycle -> all outputs return to their reset values on the next clk. Relock takes 4 periods.
